mips32_multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS32 SoC CPU. It replaces single-cycle combinational decode with a registered FSM: FETCH, DECODE, EXEC, MEM, WB. Memory accesses use a ready handshake with a parametrised timeout. Decode drives the datapath muxes, the ALU, the register file and the memory interface; invalid opcodes and bus timeouts trap into a sticky state.

---
 rtl/mips32_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mips32_multicycle_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_multicycle_ctrl.sv
// Multi-cycle MIPS32 control unit: FETCH/DECODE/EXEC/MEM/WB FSM
// with a memory-ready timeout and sticky trap flags.
module mips32_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit EN_SUBWORD  = 1'b1,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       aluZero,
  input  logic       memReady,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       memRead,
  output logic       memWrite,
  output logic       iorD,
  output logic [1:0] memDataSize,
  output logic       memBitExt,
  output logic       rfWriteEnable,
  output logic       rfWriteAddrSel,
  output logic [1:0] rfWriteDataSel,
  output logic       aluSrc,
  output logic [2:0] aluFunc,
  output logic       bitXtend,
  output logic       isLui,
  output logic       invOpcode,
  output logic       memErr,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_func;
    logic       bit_xtend;
    logic       is_lui;
    logic       wa_sel;
    logic [1:0] wd_sel;
    logic [1:0] dsize;
    logic       bit_ext;
    logic       ld;
    logic       st;
    logic       beq;
    logic       bne;
    logic       jmp;
  } ctrl_t;

  state_t           cur;
  state_t           nxt;
  ctrl_t            ctl;
  ctrl_t            dec;
  logic             dec_ok;
  logic [TMO_W-1:0] cnt;
  logic             tmo;
  logic             waiting;

  assign tmo     = (cnt == TMO_MAX);
  assign waiting = (cur == S_FETCH || cur == S_MEM) && !memReady;

  // Instruction decode into the control bundle latched at DECODE
  always_comb begin
    dec    = '0;
    dec_ok = 1'b1;
    unique case (opc)
      6'h00: begin
        dec.wa_sel = 1'b1;
        unique case (func)
          6'h20, 6'h21: dec.alu_func = ALU_ADD;
          6'h22: dec.alu_func = ALU_SUB;
          6'h23: begin
            dec.alu_func  = ALU_SUB;
            dec.bit_xtend = 1'b1;
          end
          6'h24: dec.alu_func = ALU_AND;
          6'h25: dec.alu_func = ALU_OR;
          6'h26: dec.alu_func = ALU_XOR;
          6'h2A: dec.alu_func = ALU_SLT;
          6'h2B: begin
            dec.alu_func  = ALU_SLT;
            dec.bit_xtend = 1'b1;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      6'h02: dec.jmp = 1'b1;
      6'h04: begin
        dec.alu_func = ALU_SUB;
        dec.beq      = 1'b1;
      end
      6'h05: begin
        dec.alu_func = ALU_SUB;
        dec.bne      = 1'b1;
      end
      6'h08, 6'h09: begin
        dec.alu_src  = 1'b1;
        dec.alu_func = ALU_ADD;
      end
      6'h0A, 6'h0B: begin
        dec.alu_src  = 1'b1;
        dec.alu_func = ALU_SLT;
      end
      6'h0C: begin
        dec.alu_src   = 1'b1;
        dec.alu_func  = ALU_AND;
        dec.bit_xtend = 1'b1;
      end
      6'h0D: begin
        dec.alu_src   = 1'b1;
        dec.alu_func  = ALU_OR;
        dec.bit_xtend = 1'b1;
      end
      6'h0E: begin
        dec.alu_src   = 1'b1;
        dec.alu_func  = ALU_XOR;
        dec.bit_xtend = 1'b1;
      end
      6'h0F: begin
        dec.alu_src   = 1'b1;
        dec.alu_func  = ALU_ADD;
        dec.bit_xtend = 1'b1;
        dec.is_lui    = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.alu_src = 1'b1;
        dec.ld      = 1'b1;
        dec.wd_sel  = 2'd1;
        dec.bit_ext = (opc == 6'h24) || (opc == 6'h25);
        if (opc == 6'h20 || opc == 6'h24) dec.dsize = 2'd2;
        if (opc == 6'h21 || opc == 6'h25) dec.dsize = 2'd1;
        if (opc != 6'h23) dec_ok = EN_SUBWORD;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.alu_src = 1'b1;
        dec.st      = 1'b1;
        if (opc == 6'h28) dec.dsize = 2'd2;
        if (opc == 6'h29) dec.dsize = 2'd1;
        if (opc != 6'h2B) dec_ok = EN_SUBWORD;
      end
      default: dec_ok = 1'b0;
    endcase
    if (!dec_ok) dec = '0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Control latch loaded once per instruction in DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ctl <= '0;
    else if (cur == S_DECODE) ctl <= dec;
  end

  // Wait-cycle counter, cleared on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (nxt != cur) cnt <= '0;
    else if (waiting)    cnt <= cnt + TMO_W'(1);
  end

  // Sticky trap cause flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      invOpcode <= 1'b0;
      memErr    <= 1'b0;
    end else begin
      if (cur == S_DECODE && !dec_ok) invOpcode <= 1'b1;
      if (waiting && tmo)             memErr    <= 1'b1;
    end
  end

  // Next state and per-state strobes
  always_comb begin
    nxt           = cur;
    irWrite       = 1'b0;
    pcWrite       = 1'b0;
    pcSrc         = 2'd0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    iorD          = 1'b0;
    rfWriteEnable = 1'b0;
    unique case (cur)
      S_FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          nxt     = S_DECODE;
        end else if (tmo) begin
          nxt = S_TRAP;
        end
      end
      S_DECODE: nxt = dec_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        nxt = S_WB;
        if (ctl.beq) begin
          pcWrite = aluZero;
          pcSrc   = 2'd1;
          nxt     = S_FETCH;
        end else if (ctl.bne) begin
          pcWrite = !aluZero;
          pcSrc   = 2'd1;
          nxt     = S_FETCH;
        end else if (ctl.jmp) begin
          pcWrite = 1'b1;
          pcSrc   = 2'd2;
          nxt     = S_FETCH;
        end else if (ctl.ld || ctl.st) begin
          nxt = S_MEM;
        end
      end
      S_MEM: begin
        iorD     = 1'b1;
        memRead  = ctl.ld;
        memWrite = ctl.st;
        if (memReady)  nxt = ctl.ld ? S_WB : S_FETCH;
        else if (tmo)  nxt = S_TRAP;
      end
      S_WB: begin
        rfWriteEnable = 1'b1;
        nxt           = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  assign state          = cur;
  assign aluSrc         = ctl.alu_src;
  assign aluFunc        = ctl.alu_func;
  assign bitXtend       = ctl.bit_xtend;
  assign isLui          = ctl.is_lui;
  assign rfWriteAddrSel = ctl.wa_sel;
  assign rfWriteDataSel = ctl.wd_sel;
  assign memDataSize    = ctl.dsize;
  assign memBitExt      = ctl.bit_ext;

endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Bench for mips32_multicycle_ctrl: decode table per instruction
// plus hand-written wait, timeout, reset and subword-disable cases.
module tb_mips32_multicycle_ctrl;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opc = '0;
  logic [5:0] func = '0;
  logic       aluZero = 1'b0;
  logic       memReady = 1'b0;

  logic       irWrite, pcWrite, memRead, memWrite, iorD;
  logic [1:0] pcSrc, memDataSize, rfWriteDataSel;
  logic       memBitExt, rfWriteEnable, rfWriteAddrSel;
  logic       aluSrc, bitXtend, isLui, invOpcode, memErr;
  logic [2:0] aluFunc, state;

  logic       irWrite_s, pcWrite_s, memRead_s, memWrite_s, iorD_s;
  logic [1:0] pcSrc_s, memDataSize_s, rfWriteDataSel_s;
  logic       memBitExt_s, rfWriteEnable_s, rfWriteAddrSel_s;
  logic       aluSrc_s, bitXtend_s, isLui_s, invOpcode_s, memErr_s;
  logic [2:0] aluFunc_s, state_s;

  mips32_multicycle_ctrl u0 (
    .clk(clk), .rst(rst), .opc(opc), .func(func),
    .aluZero(aluZero), .memReady(memReady),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .memRead(memRead), .memWrite(memWrite), .iorD(iorD),
    .memDataSize(memDataSize), .memBitExt(memBitExt),
    .rfWriteEnable(rfWriteEnable),
    .rfWriteAddrSel(rfWriteAddrSel),
    .rfWriteDataSel(rfWriteDataSel),
    .aluSrc(aluSrc), .aluFunc(aluFunc), .bitXtend(bitXtend),
    .isLui(isLui), .invOpcode(invOpcode), .memErr(memErr),
    .state(state)
  );

  mips32_multicycle_ctrl #(.EN_SUBWORD(1'b0)) u1 (
    .clk(clk), .rst(rst), .opc(opc), .func(func),
    .aluZero(aluZero), .memReady(memReady),
    .irWrite(irWrite_s), .pcWrite(pcWrite_s), .pcSrc(pcSrc_s),
    .memRead(memRead_s), .memWrite(memWrite_s), .iorD(iorD_s),
    .memDataSize(memDataSize_s), .memBitExt(memBitExt_s),
    .rfWriteEnable(rfWriteEnable_s),
    .rfWriteAddrSel(rfWriteAddrSel_s),
    .rfWriteDataSel(rfWriteDataSel_s),
    .aluSrc(aluSrc_s), .aluFunc(aluFunc_s), .bitXtend(bitXtend_s),
    .isLui(isLui_s), .invOpcode(invOpcode_s), .memErr(memErr_s),
    .state(state_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        irw;
    logic        pcw;
    logic [1:0]  pcs;
    logic        mr;
    logic        mw;
    logic        iord;
    logic        rfwe;
    logic [11:0] dp;
    logic        inv;
    logic        merr;
  } obs_t;

  typedef enum int {K_ALU, K_LD, K_ST, K_BR, K_J, K_INV} kind_t;

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  func;
    logic        zero;
    kind_t       kind;
    logic        pcw;
    logic [11:0] dp;
  } vec_t;

  obs_t expq[$];
  vec_t vt[$];
  int   n_run = 0;
  int   n_fail = 0;

  function automatic logic [11:0] dpv(
    logic src, logic [2:0] fn, logic bx, logic lui,
    logic wa, logic [1:0] wd, logic [1:0] ds, logic be);
    return {src, fn, bx, lui, wa, wd, ds, be};
  endfunction

  function automatic obs_t mk(
    logic [2:0] st, logic irw, logic pcw, logic [1:0] pcs,
    logic mr, logic mw, logic iord, logic rfwe,
    logic [11:0] dp, logic inv, logic merr);
    obs_t o;
    o.st = st; o.irw = irw; o.pcw = pcw; o.pcs = pcs;
    o.mr = mr; o.mw = mw; o.iord = iord; o.rfwe = rfwe;
    o.dp = dp; o.inv = inv; o.merr = merr;
    return o;
  endfunction

  function automatic vec_t mkv(
    logic [5:0] o, logic [5:0] f, logic z,
    kind_t k, logic pcw, logic [11:0] dp);
    vec_t v;
    v.opc = o; v.func = f; v.zero = z;
    v.kind = k; v.pcw = pcw; v.dp = dp;
    return v;
  endfunction

  function automatic obs_t grab(bit sel);
    if (sel)
      return mk(state_s, irWrite_s, pcWrite_s, pcSrc_s,
        memRead_s, memWrite_s, iorD_s, rfWriteEnable_s,
        {aluSrc_s, aluFunc_s, bitXtend_s, isLui_s,
         rfWriteAddrSel_s, rfWriteDataSel_s,
         memDataSize_s, memBitExt_s},
        invOpcode_s, memErr_s);
    return mk(state, irWrite, pcWrite, pcSrc,
      memRead, memWrite, iorD, rfWriteEnable,
      {aluSrc, aluFunc, bitXtend, isLui,
       rfWriteAddrSel, rfWriteDataSel,
       memDataSize, memBitExt},
      invOpcode, memErr);
  endfunction

  task automatic chk(input string tag, input bit sel);
    obs_t g;
    obs_t x;
    g = grab(sel);
    x = expq.pop_front();
    n_run++;
    if (g !== x) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, g, x);
    end
  endtask

  task automatic step(input string tag, input bit sel,
                      input logic rdy, input obs_t e);
    memReady = rdy;
    expq.push_back(e);
    #2;
    chk(tag, sel);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit sel);
    @(negedge clk);
    rst = 1'b1;
    memReady = 1'b0;
    #1;
    expq.push_back(mk(3'd0, 0, 0, 2'd0, 1, 0, 0, 0, '0, 0, 0));
    chk("reset", sel);
    #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] dp_sw, dp_lw, dp_lhu;
    logic        pw;
    logic [1:0]  ps;
    obs_t        e_f0, e_tr;
    dp_sw  = dpv(1, ALU_ADD, 0, 0, 0, 2'd0, 2'd0, 0);
    dp_lw  = dpv(1, ALU_ADD, 0, 0, 0, 2'd1, 2'd0, 0);
    dp_lhu = dpv(1, ALU_ADD, 0, 0, 0, 2'd1, 2'd1, 1);

    vt.push_back(mkv(6'h00, 6'h20, 0, K_ALU, 0,
      dpv(0, ALU_ADD, 0, 0, 1, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h00, 6'h23, 0, K_ALU, 0,
      dpv(0, ALU_SUB, 1, 0, 1, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h00, 6'h24, 0, K_ALU, 0,
      dpv(0, ALU_AND, 0, 0, 1, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h00, 6'h26, 0, K_ALU, 0,
      dpv(0, ALU_XOR, 0, 0, 1, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h00, 6'h2B, 0, K_ALU, 0,
      dpv(0, ALU_SLT, 1, 0, 1, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h08, 6'h00, 0, K_ALU, 0,
      dpv(1, ALU_ADD, 0, 0, 0, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h0B, 6'h00, 0, K_ALU, 0,
      dpv(1, ALU_SLT, 0, 0, 0, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h0D, 6'h00, 0, K_ALU, 0,
      dpv(1, ALU_OR, 1, 0, 0, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h0F, 6'h00, 0, K_ALU, 0,
      dpv(1, ALU_ADD, 1, 1, 0, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h23, 6'h00, 0, K_LD, 0, dp_lw));
    vt.push_back(mkv(6'h25, 6'h00, 0, K_LD, 0, dp_lhu));
    vt.push_back(mkv(6'h20, 6'h00, 0, K_LD, 0,
      dpv(1, ALU_ADD, 0, 0, 0, 2'd1, 2'd2, 0)));
    vt.push_back(mkv(6'h2B, 6'h00, 0, K_ST, 0, dp_sw));
    vt.push_back(mkv(6'h29, 6'h00, 0, K_ST, 0,
      dpv(1, ALU_ADD, 0, 0, 0, 2'd0, 2'd1, 0)));
    vt.push_back(mkv(6'h04, 6'h00, 1, K_BR, 1,
      dpv(0, ALU_SUB, 0, 0, 0, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h04, 6'h00, 0, K_BR, 0,
      dpv(0, ALU_SUB, 0, 0, 0, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h05, 6'h00, 1, K_BR, 0,
      dpv(0, ALU_SUB, 0, 0, 0, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h05, 6'h00, 0, K_BR, 1,
      dpv(0, ALU_SUB, 0, 0, 0, 2'd0, 2'd0, 0)));
    vt.push_back(mkv(6'h02, 6'h00, 0, K_J, 1, '0));
    vt.push_back(mkv(6'h3F, 6'h00, 0, K_INV, 0, '0));
    vt.push_back(mkv(6'h00, 6'h3F, 0, K_INV, 0, '0));

    e_f0 = mk(3'd0, 1, 1, 2'd0, 1, 0, 0, 0, '0, 0, 0);

    foreach (vt[i]) begin
      do_reset(0);
      opc = vt[i].opc;
      func = vt[i].func;
      aluZero = vt[i].zero;
      step($sformatf("v%0d_fetch", i), 0, 1, e_f0);
      step($sformatf("v%0d_decode", i), 0, 1,
        mk(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, '0, 0, 0));
      if (vt[i].kind == K_INV) begin
        e_tr = mk(3'd7, 0, 0, 2'd0, 0, 0, 0, 0, '0, 1, 0);
        step($sformatf("v%0d_trap", i), 0, 1, e_tr);
        step($sformatf("v%0d_hold", i), 0, 1, e_tr);
      end else begin
        pw = 1'b0;
        ps = 2'd0;
        if (vt[i].kind == K_BR) begin
          pw = vt[i].pcw;
          ps = 2'd1;
        end
        if (vt[i].kind == K_J) begin
          pw = 1'b1;
          ps = 2'd2;
        end
        step($sformatf("v%0d_exec", i), 0, 1,
          mk(3'd2, 0, pw, ps, 0, 0, 0, 0, vt[i].dp, 0, 0));
        if (vt[i].kind == K_LD)
          step($sformatf("v%0d_mem", i), 0, 1,
            mk(3'd3, 0, 0, 2'd0, 1, 0, 1, 0, vt[i].dp, 0, 0));
        if (vt[i].kind == K_ST)
          step($sformatf("v%0d_mem", i), 0, 1,
            mk(3'd3, 0, 0, 2'd0, 0, 1, 1, 0, vt[i].dp, 0, 0));
        if (vt[i].kind == K_ALU || vt[i].kind == K_LD)
          step($sformatf("v%0d_wb", i), 0, 1,
            mk(3'd4, 0, 0, 2'd0, 0, 0, 0, 1, vt[i].dp, 0, 0));
        step($sformatf("v%0d_refetch", i), 0, 0,
          mk(3'd0, 0, 0, 2'd0, 1, 0, 0, 0, vt[i].dp, 0, 0));
      end
    end

    // LHU with three wait cycles in MEM
    do_reset(0);
    opc = 6'h25;
    step("lhu_fetch", 0, 1, e_f0);
    step("lhu_decode", 0, 0,
      mk(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, '0, 0, 0));
    step("lhu_exec", 0, 0,
      mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, dp_lhu, 0, 0));
    for (int k = 0; k < 4; k++)
      step($sformatf("lhu_mem%0d", k), 0, (k == 3),
        mk(3'd3, 0, 0, 2'd0, 1, 0, 1, 0, dp_lhu, 0, 0));
    step("lhu_wb", 0, 0,
      mk(3'd4, 0, 0, 2'd0, 0, 0, 0, 1, dp_lhu, 0, 0));

    // Reset in the middle of a LW data wait
    do_reset(0);
    opc = 6'h23;
    step("rmid_fetch", 0, 1, e_f0);
    step("rmid_decode", 0, 0,
      mk(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, '0, 0, 0));
    step("rmid_exec", 0, 0,
      mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, dp_lw, 0, 0));
    step("rmid_mem", 0, 0,
      mk(3'd3, 0, 0, 2'd0, 1, 0, 1, 0, dp_lw, 0, 0));
    do_reset(0);
    step("rmid_after", 0, 0,
      mk(3'd0, 0, 0, 2'd0, 1, 0, 0, 0, '0, 0, 0));

    // Fetch timeout: 15 counted waits, trap on the next idle cycle
    do_reset(0);
    opc = 6'h00;
    func = 6'h20;
    for (int k = 0; k < 16; k++)
      step($sformatf("tmo_wait%0d", k), 0, 0,
        mk(3'd0, 0, 0, 2'd0, 1, 0, 0, 0, '0, 0, 0));
    e_tr = mk(3'd7, 0, 0, 2'd0, 0, 0, 0, 0, '0, 0, 1);
    step("tmo_trap", 0, 0, e_tr);
    step("tmo_hold", 0, 1, e_tr);
    step("tmo_hold2", 0, 1, e_tr);

    // Ready arriving exactly when the count reaches the limit
    do_reset(0);
    for (int k = 0; k < 15; k++)
      step($sformatf("edge_wait%0d", k), 0, 0,
        mk(3'd0, 0, 0, 2'd0, 1, 0, 0, 0, '0, 0, 0));
    step("edge_accept", 0, 1, e_f0);
    step("edge_decode", 0, 0,
      mk(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, '0, 0, 0));

    // Store data-phase timeout
    do_reset(0);
    opc = 6'h2B;
    step("mtmo_fetch", 0, 1, e_f0);
    step("mtmo_decode", 0, 0,
      mk(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, '0, 0, 0));
    step("mtmo_exec", 0, 0,
      mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, dp_sw, 0, 0));
    for (int k = 0; k < 16; k++)
      step($sformatf("mtmo_wait%0d", k), 0, 0,
        mk(3'd3, 0, 0, 2'd0, 0, 1, 1, 0, dp_sw, 0, 0));
    step("mtmo_trap", 0, 1,
      mk(3'd7, 0, 0, 2'd0, 0, 0, 0, 0, dp_sw, 0, 1));

    // Subword opcode with subword support disabled
    do_reset(1);
    opc = 6'h20;
    step("nosub_fetch", 1, 1, e_f0);
    step("nosub_decode", 1, 1,
      mk(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, '0, 0, 0));
    e_tr = mk(3'd7, 0, 0, 2'd0, 0, 0, 0, 0, '0, 1, 0);
    for (int k = 0; k < 3; k++)
      step($sformatf("nosub_trap%0d", k), 1, 1, e_tr);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
